// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel input synchroniser, debouncer and edge detector
//
// Purpose:
//   Conditions WIDTH asynchronous board inputs (buttons, switches, strobes).
//   Each channel has its own SYNC_STAGES-deep synchroniser, then a debouncer
//   that needs DEBOUNCE_CYCLES consecutive disagreeing samples before it
//   changes the output. A one-cycle rise/fall pulse is registered on the same
//   edge that updates the output.
//
// Ports:
//   clk    in   1      system clock, single domain
//   reset  in   1      synchronous, active-high reset
//   in     in   WIDTH  raw asynchronous inputs
//   out    out  WIDTH  synchronised, debounced level
//   rise   out  WIDTH  one-cycle pulse when out[i] goes 0->1
//   fall   out  WIDTH  one-cycle pulse when out[i] goes 1->0
//
// Build option:
//   INPUT_COND_BYPASS_EN - simulation speed-up. Removes the synchroniser and
//   debouncer: out follows in combinationally, and rise/fall are derived
//   from a single registered copy of in. SYNC_STAGES and DEBOUNCE_CYCLES are
//   then ignored. Leave undefined for synthesis.

module input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Reject meaningless configurations at elaboration time.
    if (WIDTH < 1) begin : g_bad_width
        $error("input_conditioner: WIDTH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("input_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

`ifdef INPUT_COND_BYPASS_EN

    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= in;
        end
    end

    assign out  = in;
    assign rise = in & ~prev_q;
    assign fall = ~in & prev_q;

`else

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // sync_q[0] is the metastability-catching flop; the last stage is the
    // only one the debouncer is allowed to look at.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Per-channel debounce. Any sample that agrees with the current output
    // clears the count, so only an unbroken run of DEBOUNCE_CYCLES
    // disagreeing samples can flip the output; the count restarts from zero
    // at the flip, so it never needs to saturate.
    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_s[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                out_d[i]  = sync_s[i];
                cnt_d[i]  = '0;
                rise_d[i] = sync_s[i];
                fall_d[i] = ~sync_s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Reset forces out low without a fall pulse: pulses describe debounced
    // transitions only, never the reset itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench for input_conditioner

module tb_input_conditioner;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_v;
    logic [W-1:0] out_v;
    logic [W-1:0] rise_v;
    logic [W-1:0] fall_v;

    input_conditioner #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .in   (in_v),
        .out  (out_v),
        .rise (rise_v),
        .fall (fall_v)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model. The synchroniser is a pure delay: the sample the
    // debouncer sees at edge e is the input captured S edges earlier, or 0
    // if any reset edge lies in that span. The debouncer is described as a
    // sliding window: the output flips exactly when the last D samples seen
    // since reset all disagree with it.
    logic [W-1:0] hist[$];
    int           edge_n   = 0;
    int           last_rst = 0;
    bit           win[W][$];
    logic [W-1:0] m_out    = '0;
    logic [W-1:0] m_rise   = '0;
    logic [W-1:0] m_fall   = '0;

    task automatic model_edge(input logic [W-1:0] d, input logic r);
        logic [W-1:0] s_pre;
        bit           all_diff;
        edge_n++;
        hist.push_back(r ? '0 : d);
        if (r) begin
            last_rst = edge_n;
            m_out    = '0;
            m_rise   = '0;
            m_fall   = '0;
            for (int ch = 0; ch < W; ch++) win[ch].delete();
        end else begin
            if (edge_n - S < 1 || last_rst >= edge_n - S + 1) s_pre = '0;
            else                                              s_pre = hist[edge_n-S-1];
            m_rise = '0;
            m_fall = '0;
            for (int ch = 0; ch < W; ch++) begin
                win[ch].push_back(s_pre[ch]);
                if (win[ch].size() > D) void'(win[ch].pop_front());
                if (win[ch].size() == D) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < D; k++) begin
                        if (win[ch][k] == m_out[ch]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        m_out[ch] = ~m_out[ch];
                        if (m_out[ch]) m_rise[ch] = 1'b1;
                        else           m_fall[ch] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [W-1:0] d, input logic r);
        @(negedge clk);
        in_v  = d;
        reset = r;
        @(posedge clk);
        #1;
        model_edge(d, r);
        check_eq($sformatf("out@%0d", edge_n), 32'(out_v), 32'(m_out));
        check_eq($sformatf("rise@%0d", edge_n), 32'(rise_v), 32'(m_rise));
        check_eq($sformatf("fall@%0d", edge_n), 32'(fall_v), 32'(m_fall));
        check_eq($sformatf("rise_and_fall@%0d", edge_n), 32'(rise_v & fall_v), 32'd0);
    endtask

    task automatic hold(input logic [W-1:0] d, input int n);
        for (int k = 0; k < n; k++) step(d, 1'b0);
    endtask

    // Holds d and reports the step at which the masked output first equals
    // d, plus the pulses seen on that step. Bounded at 12 steps.
    task automatic measure(input logic [W-1:0] d, input logic [W-1:0] mask, input string tag,
                           output logic [W-1:0] r_at, output logic [W-1:0] f_at);
        int lat;
        lat  = 0;
        r_at = '0;
        f_at = '0;
        for (int k = 1; k <= 12; k++) begin
            step(d, 1'b0);
            if (lat == 0 && (out_v & mask) == (d & mask)) begin
                lat  = k;
                r_at = rise_v;
                f_at = fall_v;
            end
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(S + D));
    endtask

    logic [W-1:0] r_at;
    logic [W-1:0] f_at;
    logic [W-1:0] cur;
    int           hold_left[W];

    initial begin
        in_v  = '0;
        reset = 1'b1;

        // 1: reset with inputs high, then release.
        for (int k = 0; k < 3; k++) step(4'hF, 1'b1);
        measure(4'hF, 4'hF, "t1", r_at, f_at);
        check_eq("t1_rise", 32'(r_at), 32'hF);

        // 2: clean step on channel 0, up then down.
        step(4'h0, 1'b1);
        measure(4'h1, 4'h1, "t2_up", r_at, f_at);
        check_eq("t2_rise", 32'(r_at), 32'h1);
        measure(4'h0, 4'h1, "t2_dn", r_at, f_at);
        check_eq("t2_fall", 32'(f_at), 32'h1);

        // 3: 3-cycle glitch rejected, 4-cycle pulse passes.
        hold(4'h2, 3);
        hold(4'h0, 8);
        hold(4'h2, 4);
        hold(4'h0, 10);

        // 4: bounce on channel 2 before settling high, then low.
        foreach (cur[b]) cur[b] = 1'b0;
        begin
            bit pat[9];
            pat = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
            for (int k = 0; k < 9; k++) step(pat[k] ? 4'h4 : 4'h0, 1'b0);
        end
        hold(4'h4, 6);
        hold(4'h0, 8);

        // 5: all channels change together.
        step(4'h0, 1'b1);
        hold(4'h5, 8);
        measure(4'hA, 4'hF, "t5", r_at, f_at);
        check_eq("t5_rise", 32'(r_at), 32'hA);
        check_eq("t5_fall", 32'(f_at), 32'h5);

        // 6: reset while channel 3 is mid-count back towards 0.
        step(4'h0, 1'b1);
        hold(4'h8, 8);
        hold(4'h0, 4);
        step(4'h8, 1'b1);
        measure(4'h8, 4'h8, "t6", r_at, f_at);
        check_eq("t6_rise", 32'(r_at), 32'h8);

        // Input toggling every cycle must never move the output.
        for (int k = 0; k < 20; k++) step((k % 2) ? 4'hF : 4'h0, 1'b0);

        // Randomised: each channel holds a level for 1..8 cycles, with
        // occasional resets.
        cur = '0;
        for (int ch = 0; ch < W; ch++) hold_left[ch] = 1;
        for (int k = 0; k < 1500; k++) begin
            for (int ch = 0; ch < W; ch++) begin
                hold_left[ch]--;
                if (hold_left[ch] == 0) begin
                    cur[ch]       = ~cur[ch];
                    hold_left[ch] = int'($urandom_range(1, 8));
                end
            end
            step(cur, ($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised multi-channel conditioner for asynchronous board inputs such as buttons, switches and external strobes. Each channel passes through a configurable-depth synchroniser, then a consecutive-sample debouncer. The block outputs a clean level plus single-cycle rise and fall pulses. It sits between top-level pins and all control FSMs, and replaces the fixed single-bit two-flop synchroniser.

Parameters:
WIDTH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 4, consecutive agreeing synchronised samples required to change the output (>=1); counter width is $clog2(DEBOUNCE_CYCLES)+1

Ports:
clk  input  1  system clock; single clock domain for all state
reset  input  1  synchronous, active-high reset
in  input  WIDTH  raw asynchronous inputs
out  output  WIDTH  synchronised, debounced level
rise  output  WIDTH  one-cycle pulse when out[i] goes 0->1
fall  output  WIDTH  one-cycle pulse when out[i] goes 1->0

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- All state is registered on posedge clk. Reset is sampled only at a clock edge; there is no asynchronous clear.
- Reset: all sync flops = 0, counters = 0, out = 0, rise = 0, fall = 0.
- Channels are fully independent; there is no shared state between channels.
- Sync chain, per channel i: s0 <= in[i], s1 <= s0, and so on. The final stage is s[i], available after SYNC_STAGES edges.
- Debounce, per channel, evaluated each edge when not in reset:
  - if s[i] == out[i]: cnt <= 0, hold out.
  - else if cnt == DEBOUNCE_CYCLES-1: out[i] <= s[i], cnt <= 0.
  - else: cnt <= cnt+1.
- Edge pulses are registered in the same edge that updates out[i]:
  - rise[i] <= 1 if out[i] is updated to 1, else 0.
  - fall[i] <= 1 if out[i] is updated to 0, else 0.
  - Each pulse is exactly one cycle. rise and fall are never both high on the same channel.
- Latency:
  - A clean input step first sampled at edge 1 appears on out at edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - With defaults that is edge 6.
  - With DEBOUNCE_CYCLES=1 the latency is SYNC_STAGES+1.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES synchronised samples never changes out. Any agreeing sample clears cnt, so counting is not cumulative.
- Boundaries:
  - Counter saturation cannot occur, because it is cleared on reaching DEBOUNCE_CYCLES-1.
  - An input toggling every cycle never changes out when DEBOUNCE_CYCLES>=2.
- Reset mid-operation: any in-flight count is discarded and out is forced to 0 with no fall pulse. After release, an input held high produces out=1 and a rise pulse at edge SYNC_STAGES+DEBOUNCE_CYCLES after release.
- Simultaneous changes on several channels are handled in parallel, and pulses may coincide.
- Elaboration error if WIDTH<1, SYNC_STAGES<2 or DEBOUNCE_CYCLES<1.

Optional Feature:
Macro: INPUT_COND_BYPASS_EN (simulation speed-up, off for synthesis).
- Defined:
  - Sync chain and debounce counters are removed, and out = in combinationally.
  - A single prev register per channel (reset 0, prev <= in) drives rise = in & ~prev and fall = ~in & prev combinationally.
  - Parameters SYNC_STAGES and DEBOUNCE_CYCLES are ignored.
- Undefined: full behaviour as specified above.

Test Plan:
1. Reset held 3 cycles with in=4'hF -> out, rise and fall = 0 throughout. After release, out=4'hF at edge 6, and rise=4'hF for exactly that one cycle.
2. in[0] 0->1 held clean (defaults) -> out[0]=1 at edge 6 after first sampling, rise[0] single pulse; later 1->0 -> out[0]=0 at edge 6 with a single fall[0] pulse.
3. in[1] glitch high for 3 cycles, then low -> out[1] stays 0 and no rise pulse. A 4-cycle high pulse -> out[1] rises, then falls 4 edges after it is synchronised low.
4. in[2] bounce pattern 1,0,1,1,0,1,1,1,1 -> cnt clears on each 0. out[2] rises only after the final 4 consecutive 1s reach s[2].
5. in=4'b0101 changed to 4'b1010 in one cycle -> rise=4'b1010 and fall=4'b0101 in the same cycle, at edge 6.
6. Reset asserted while cnt[3]=2 with out[3]=1 -> out[3]=0 next edge with no fall pulse. After release, in[3] still high -> out[3]=1 and rise[3] pulse at edge 6.
